// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner/encoder.
package keypad_pkg;

  localparam int KEY_W = 4;
  localparam int N_ROW = 4;
  localparam int N_COL = 4;

  localparam logic [N_ROW-1:0] ROW_IDLE = 4'hF;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  // Index of the lowest active-low row; lowest row wins when several are closed.
  function automatic logic [1:0] lowest_low(input logic [N_ROW-1:0] rows);
    logic found;
    lowest_low = 2'd0;
    found      = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!rows[i] && !found) begin
        lowest_low = i[1:0];
        found      = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-event bundle; master is the encoder, slave is the board/consumer side.
interface keypad_if;
  import keypad_pkg::*;

  logic [N_ROW-1:0] row_in;
  logic [N_COL-1:0] col_out;
  logic [KEY_W-1:0] key_code;
  logic             key_valid;
  logic             key_held;

  modport master (input row_in, output col_out, key_code, key_valid, key_held);
  modport slave  (output row_in, input col_out, key_code, key_valid, key_held);

endinterface

// File: rtl/m_keypad_sync.sv
// Parameterized-width two-flop synchronizer with asynchronous active-high reset.
module m_keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/m_keypad_encoder.sv
// 4x4 keypad scanner: column scan, debounce, hex encode with one-cycle strobe.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module m_keypad_encoder
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int DEBOUNCE_CNT = 65536,
  parameter int REPEAT_CNT   = 1048576
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int STAB_W  = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [STAB_W-1:0]  STAB_LAST  = STAB_W'(DEBOUNCE_CNT - 1);

  if (SCAN_DIV < 4 || DEBOUNCE_CNT < 1 || REPEAT_CNT < 1) begin : g_bad_params
    $error("m_keypad_encoder: SCAN_DIV must be >= 4, counts must be positive");
  end

  state_t           state;
  logic [N_ROW-1:0] rs;
  logic [N_ROW-1:0] pattern;
  logic [1:0]       col;
  logic [1:0]       row;
  logic [DWELL_W-1:0] dwell;
  logic [STAB_W-1:0]  stab;

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CNT + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CNT - 1);
  logic [REP_W-1:0] rep;
`endif

  m_keypad_sync #(.WIDTH(N_ROW)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (kp.row_in),
    .q   (rs)
  );

  assign kp.col_out = ~(N_COL'(1) << col);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= SCAN;
      col          <= '0;
      row          <= '0;
      pattern      <= '0;
      dwell        <= '0;
      stab         <= '0;
      kp.key_code  <= '0;
      kp.key_valid <= 1'b0;
      kp.key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep          <= '0;
`endif
    end else begin
      kp.key_valid <= 1'b0;
      unique case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (rs == ROW_IDLE) begin
              col <= col + 2'd1;
            end else begin
              pattern <= rs;
              row     <= lowest_low(rs);
              stab    <= '0;
              state   <= DEBOUNCE;
            end
          end else begin
            dwell <= dwell + 1'b1;
          end
        end

        DEBOUNCE: begin
          if (rs != pattern) begin
            state <= SCAN;
            col   <= col + 2'd1;
            dwell <= '0;
            stab  <= '0;
          end else if (stab == STAB_LAST) begin
            // Count completes on this edge, so the strobe lands one cycle after it.
            kp.key_code  <= {row, col};
            kp.key_valid <= 1'b1;
            kp.key_held  <= 1'b1;
            stab         <= '0;
            state        <= HELD;
          end else begin
            stab <= stab + 1'b1;
          end
        end

        HELD: begin
          if (rs[row]) begin
            state <= RELEASE;
            stab  <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep   <= '0;
          end else if (rep == REP_LAST) begin
            rep          <= '0;
            kp.key_valid <= 1'b1;
          end else begin
            rep <= rep + 1'b1;
`endif
          end
        end

        RELEASE: begin
          if (!rs[row]) begin
            state <= HELD;
            stab  <= '0;
          end else if (stab == STAB_LAST) begin
            kp.key_held <= 1'b0;
            state       <= SCAN;
            col         <= '0;
            dwell       <= '0;
            stab        <= '0;
          end else begin
            stab <= stab + 1'b1;
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_m_keypad_encoder.sv
// Self-checking bench for m_keypad_encoder with a behavioural keypad matrix model.
module tb_m_keypad_encoder;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 8;
  localparam int REPEAT_CNT   = 16;

  logic clk = 1'b0;
  logic rst;
  keypad_if kif ();

  m_keypad_encoder #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_CNT   (REPEAT_CNT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a closed key (r,c) pulls row r low while column c is driven low.
  logic pressed [4][4];
  always_comb begin
    kif.row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && !kif.col_out[c]) kif.row_in[r] = 1'b0;
  end

  logic [3:0] strobes [$];
  always @(negedge clk) if (kif.key_valid) strobes.push_back(kif.key_code);

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic release_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
  endtask

  task automatic wait_strobe(input int base, output bit got);
    int n;
    n = 0;
    while (strobes.size() <= base && n < 80) begin
      tick(1);
      n++;
    end
    got = (strobes.size() > base);
  endtask

  task automatic wait_release(output int n);
    n = 0;
    while (kif.key_held && n < 60) begin
      tick(1);
      n++;
    end
  endtask

  function automatic logic [3:0] walk_col(input int k);
    int idx;
    idx      = (k / SCAN_DIV) % 4;
    walk_col = ~(4'b0001 << idx);
  endfunction

  function automatic logic [3:0] model_code(input int r, input int c);
    model_code = 4'((r * 4) + c);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs [5];
    bit         got;
    int         base, n, exp_rep, hold, r, c;
    logic [3:0] last_code, c0;

    vecs[0] = '{r: 2, c: 1, code: 4'h9};
    vecs[1] = '{r: 0, c: 0, code: 4'h0};
    vecs[2] = '{r: 3, c: 3, code: 4'hF};
    vecs[3] = '{r: 1, c: 2, code: 4'h6};
    vecs[4] = '{r: 0, c: 3, code: 4'h3};

    release_all();
    rst = 1'b1;
    tick(3);
    chk("rst_col_out", kif.col_out, 4'b1110);
    chk("rst_key_code", kif.key_code, 4'h0);
    chk("rst_key_valid", kif.key_valid, 1'b0);
    chk("rst_key_held", kif.key_held, 1'b0);
    last_code = 4'h0;

    rst = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      chk("scan_walk", kif.col_out, walk_col(k));
      tick(1);
    end

    foreach (vecs[i]) begin
      base = strobes.size();
      pressed[vecs[i].r][vecs[i].c] = 1'b1;
      wait_strobe(base, got);
      chk("tbl_strobe_seen", got, 1'b1);
      tick(10);
      chk("tbl_strobe_count", strobes.size() - base, 1);
      if (strobes.size() > base) chk("tbl_strobe_code", strobes[base], vecs[i].code);
      chk("tbl_key_code", kif.key_code, vecs[i].code);
      chk("tbl_key_held", kif.key_held, 1'b1);
      last_code = vecs[i].code;
      pressed[vecs[i].r][vecs[i].c] = 1'b0;
      wait_release(n);
      chk_range("tbl_release_delay", n, 9, 13);
      chk("tbl_rescan_col0", kif.col_out, 4'b1110);
      tick(5);
    end

    // Bounce on key (1,3): alternating every clock never reaches a full debounce.
    base = strobes.size();
    for (int i = 0; i < 20; i++) begin
      pressed[1][3] = (i[0] == 1'b0);
      tick(1);
    end
    pressed[1][3] = 1'b0;
    tick(40);
    chk("bounce_no_strobe", strobes.size() - base, 0);
    chk("bounce_key_code", kif.key_code, last_code);
    chk("bounce_key_held", kif.key_held, 1'b0);
    c0 = kif.col_out;
    tick(SCAN_DIV);
    chk("bounce_scanning", (kif.col_out != c0), 1'b1);

    // Two keys in column 0: lowest row wins; key in another column ignored while held.
    base = strobes.size();
    pressed[1][0] = 1'b1;
    pressed[3][0] = 1'b1;
    wait_strobe(base, got);
    chk("multi_strobe_seen", got, 1'b1);
    if (strobes.size() > base) chk("multi_strobe_code", strobes[base], model_code(1, 0));
    last_code = model_code(1, 0);
    pressed[0][2] = 1'b1;
    tick(12);
    chk("multi_no_new_strobe", strobes.size() - base, 1);
    chk("multi_key_code", kif.key_code, last_code);
    chk("multi_key_held", kif.key_held, 1'b1);
    release_all();
    wait_release(n);
    chk("multi_released", kif.key_held, 1'b0);
    tick(10);

    // Reset three clocks into DEBOUNCE on key (2,0).
    rst = 1'b1;
    pressed[2][0] = 1'b1;
    tick(2);
    rst = 1'b0;
    base = strobes.size();
    tick(SCAN_DIV + 3);
    rst = 1'b1;
    #1;
    chk("midrst_col_out", kif.col_out, 4'b1110);
    chk("midrst_key_code", kif.key_code, 4'h0);
    chk("midrst_key_valid", kif.key_valid, 1'b0);
    chk("midrst_key_held", kif.key_held, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(SCAN_DIV + DEBOUNCE_CNT - 2);
    chk("midrst_no_early_strobe", strobes.size() - base, 0);
    wait_strobe(base, got);
    chk("midrst_strobe_seen", got, 1'b1);
    if (strobes.size() > base) chk("midrst_strobe_code", strobes[base], model_code(2, 0));
    last_code = model_code(2, 0);
    release_all();
    wait_release(n);
    tick(10);

    // Long hold of key (3,3): auto-repeat only when the feature is built in.
`ifdef KEYPAD_REPEAT_EN
    exp_rep = 1 + 60 / REPEAT_CNT;
`else
    exp_rep = 1;
`endif
    base = strobes.size();
    pressed[3][3] = 1'b1;
    wait_strobe(base, got);
    chk("repeat_strobe_seen", got, 1'b1);
    tick(60);
    chk("repeat_count", strobes.size() - base, exp_rep);
    for (int i = base; i < strobes.size(); i++) chk("repeat_code", strobes[i], 4'hF);
    last_code = 4'hF;
    release_all();
    wait_release(n);
    tick(10);

    // Randomized presses against the keypad reference model.
    for (int it = 0; it < 12; it++) begin
      r    = $urandom_range(0, 3);
      c    = $urandom_range(0, 3);
      base = strobes.size();
      pressed[r][c] = 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        tick($urandom_range(1, 3));
        pressed[r][c] = 1'b0;
        tick(30);
        chk("rnd_glitch_count", strobes.size() - base, 0);
        chk("rnd_glitch_code", kif.key_code, last_code);
      end else begin
        hold = $urandom_range(40, 70);
        tick(hold);
        pressed[r][c] = 1'b0;
        wait_release(n);
        chk("rnd_released", kif.key_held, 1'b0);
        tick(20);
`ifdef KEYPAD_REPEAT_EN
        chk("rnd_strobe_present", (strobes.size() - base) >= 1, 1'b1);
`else
        chk("rnd_strobe_count", strobes.size() - base, 1);
`endif
        for (int i = base; i < strobes.size(); i++) chk("rnd_strobe_code", strobes[i], model_code(r, c));
        last_code = model_code(r, c);
        chk("rnd_key_code", kif.key_code, last_code);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_keypad_encoder.md
# m_keypad_encoder

4x4 matrix keypad scanner and encoder: drives keypad columns one at a time, samples the rows, debounces a detected closure and emits a 4-bit hex key code with a one-cycle valid strobe. It is the input-side counterpart of the seven-segment decoder: keys in, hex code out. It sits between the board keypad pins and the stopwatch/control logic, which consumes key_code on key_valid.

## Interface
- SCAN_DIV, 1024: clocks each column is driven before its rows are sampled; legal minimum 4.
- DEBOUNCE_CNT, 65536: consecutive identical synchronized samples required to accept a press or a release.
- REPEAT_CNT, 1048576: auto-repeat interval in clocks; used only with KEYPAD_REPEAT_EN.
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- row_in  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
- col_out  out  4  column drive, active-low, exactly one bit low at all times.
- key_code  out  4  last accepted key; code = row*4 + col.
- key_valid  out  1  one-cycle strobe; key_code is valid in the same cycle.
- key_held  out  1  high while the accepted key remains pressed.

## Operation
- row_in passes through a 2-flop synchronizer; all logic uses the synchronized value rs.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN: col_out = ~(1<<col). Dwell counter counts 0..SCAN_DIV-1. On the last dwell cycle, rs is sampled. If rs == 4'hF, col advances (3 wraps to 0) and dwell restarts. Otherwise the pattern is captured, row = lowest index with rs bit low, and the state goes to DEBOUNCE; col is held.
- DEBOUNCE: stability counter increments each cycle rs equals the captured pattern. Any mismatch returns to SCAN with the next column and clears the counter. When the counter reaches DEBOUNCE_CNT, key_code <= {row,col}, key_valid pulses, key_held <= 1, and the state goes to HELD.
- HELD: col is held. The first cycle with rs bit[row] high enters RELEASE with the counter cleared.
- RELEASE: the counter increments each cycle rs bit[row] is high. A low sample returns to HELD. At DEBOUNCE_CNT, key_held <= 0 and the state goes to SCAN at column 0.
- Multiple keys in one column: lowest row wins. Keys in other columns are ignored until release.
- key_code holds its last value until the next accepted press.
- Counter widths are $clog2(max count + 1). No counter wraps; each is cleared on every state change.

## Timing
- Reset values: col_out = 4'b1110, key_code = 4'h0, key_valid = 0, key_held = 0, state SCAN, col = 0, all counters and synchronizer flops 0 (rs reads 4'h0 only during reset).
- First sample after reset uses a synchronizer that has been refilled for SCAN_DIV ≥ 4 cycles.
- Pad-to-rs latency: 2 clocks.
- Press-to-key_valid: sample cycle + DEBOUNCE_CNT clocks; the strobe is registered and asserted in the cycle after the count is reached.
- Worst-case detection delay: 4*SCAN_DIV clocks.
- key_held falls in the same cycle the release counter completes.
- rst mid-operation: every output returns to its reset value asynchronously; no strobe is emitted on deassertion.

## Configuration
- KEYPAD_REPEAT_EN defined: in HELD, a repeat counter runs from entry. Every REPEAT_CNT clocks, key_valid re-pulses with an unchanged key_code. The repeat counter is cleared when the state leaves HELD.
- KEYPAD_REPEAT_EN undefined: exactly one key_valid per accepted press. The repeat counter and REPEAT_CNT logic are absent.

## Structure
- keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD, RELEASE);
  - KEY_W = 4, N_ROW = 4, N_COL = 4;
  - the idle row constant 4'hF.
- One sub-module, m_keypad_sync: a parameterized-width 2-flop synchronizer with async active-high reset.
- FSM, counters and encoder stay in m_keypad_encoder.

## Test plan
Bench uses SCAN_DIV=4, DEBOUNCE_CNT=8, REPEAT_CNT=16; a keypad model pulls row r low while column c is driven low.
- Reset: assert rst -> col_out=1110, key_code=0, key_valid=0, key_held=0; after release, col_out walks 1110→1101→1011→0111→1110 every 4 clocks.
- Hold key (row 2, col 1) for 100 clocks -> exactly one key_valid with key_code=4'h9; key_held high until 8 clocks (+2 sync) after release; then scan restarts at column 0.
- Bounce: key (1,3) closes and opens on alternating clocks for 20 clocks, then opens -> no key_valid, key_code unchanged, scanning continues.
- Keys (1,0) and (3,0) pressed together -> key_code=4'h4. Pressing key (0,2) while (1,0) is held -> no new strobe.
- rst asserted 3 clocks into DEBOUNCE -> outputs at reset values immediately; no strobe after deassertion until a full new debounce completes.
- KEYPAD_REPEAT_EN: hold key (3,3) 60 clocks past acceptance -> initial strobe plus 3 repeats, all with key_code=4'hF. Without the macro, the same stimulus gives exactly one strobe.
